result_check_unit: RTL and testbench
====================================

// Module: result_check_unit
// PURPOSE
//  Downstream stage of the adder test harness: after a test run, walks the result RAM and the
//  expected-value RAM over [start, end), compares word by word, and counts mismatches.
//  Records the first failing address and its result word for HPS inspection.
//  Avalon-MM slave on the fabric clock; drives the read ports of both RAMs.
// PARAMETERS
//  ID      2   value returned at register 3
//  DATA_W  32  RAM word width (1..32)
//  ADDR_W  11  RAM address width; internal counter is ADDR_W+1 bits
//  RD_LAT  2   RAM read latency in cycles, from address to data (>=1)
// PORTS
//  avalon_clock  in   1       sole clock
//  reset         in   1       synchronous, active-high
//  write         in   1       Avalon write strobe
//  read          in   1       Avalon read strobe
//  address       in   3       register index
//  writedata     in   32      Avalon write data
//  readdata      out  32      registered read data
//  r_addr_res    out  ADDR_W  result-RAM read address
//  r_addr_exp    out  ADDR_W  expected-RAM read address (always equals r_addr_res)
//  res_data      in   DATA_W  result-RAM q, RD_LAT cycles after address
//  exp_data      in   DATA_W  expected-RAM q, RD_LAT cycles after address
// BEHAVIOUR
//  Registers:
//   0  W: bit0=1 starts, bit0=0 aborts.  R: busy.
//   1  start address, ADDR_W bits.
//   2  end address, exclusive, ADDR_W+1 bits.
//   3  ID.
//   4  error count, 32 bits.
//   5  first error: bit31 = valid, [ADDR_W-1:0] = address.
//   6  result word at first error, zero-extended.
//   7  reads 0.
//  - readdata: updated the cycle after a read with address; holds otherwise.
//  - Reset: readdata, both address outputs, all registers and counters = 0; FSM = IDLE; valid pipe cleared.
//  FSM states IDLE -> ISSUE -> DRAIN -> IDLE.
//  - IDLE, write reg0 with bit0=1:
//    - cnt<=start; error count, reg5 and reg6 <= 0; busy <= 1.
//    - Go to ISSUE if start < end, else DRAIN.
//  - ISSUE:
//    - Each cycle drive r_addr = cnt[ADDR_W-1:0].
//    - Push {valid=1, cnt} into an RD_LAT-deep tag pipe; cnt++.
//    - When cnt == end-1 is issued, go to DRAIN.
//  - DRAIN: push invalid tags; after RD_LAT cycles, go to IDLE and clear busy.
//  - Compare: when a valid tag exits the pipe and res_data != exp_data:
//    - error count +1.
//    - If reg5 is not yet valid, latch that tag address and res_data.
//  - The last compare lands in the final DRAIN cycle; busy falls the following cycle.
//  - Writes to regs 0-2 while busy are ignored, except reg0 with bit0=0.
//    That write aborts: FSM -> IDLE next cycle, tag pipe flushed, counts frozen.
//  - Writing reg0 bit0=1 while busy has no effect; a write and a read in the same cycle are both honoured.
//  - Address outputs hold their last value in IDLE.
//  - end > 2^ADDR_W is clamped to 2^ADDR_W when the run starts.
//  - Reset mid-run: everything returns to reset values; no partial counts remain.
// TESTING
//  - Memories equal, start=0 end=16 -> busy for 16+RD_LAT+1 cycles; count=0; reg5 bit31=0.
//  - Mismatches at 5 and 9 (res=0xAA at 5), start=0 end=16 -> count=2; reg5=0x80000005; reg6=0xAA.
//  - start=10 end=10 -> no RAM reads compared; busy drops after RD_LAT+1 cycles; count=0.
//  - start=2040 end=2048, all mismatched -> count=8; r_addr reaches 2047 with no wrap; reg5=0x800007F8.
//  - Abort with reg0=0 at issue #4, then reset asserted mid-run on a rerun -> busy=0 next cycle after abort; all regs read 0 after reset.
//  - Read reg3 -> readdata=2 one cycle later; write reg1 while busy -> reg1 unchanged.

Source files
------------

// File: rtl/result_check_unit.sv
// ============================================================================
//  Module   : result_check_unit
//  Brief    : Walks result/expected RAMs over [start, end), counts mismatches
//             and records the first failing address and result word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module result_check_unit #(
    parameter logic [31:0] ID     = 32'd2,
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 11,
    parameter int          RD_LAT = 2
) (
    input  logic              avalon_clock,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] r_addr_res,
    output logic [ADDR_W-1:0] r_addr_exp,
    input  logic [DATA_W-1:0] res_data,
    input  logic [DATA_W-1:0] exp_data
);

    localparam int CW = ADDR_W + 1;
    localparam int DW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CW-1:0] c_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_MAX_END = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DW-1:0] c_DRAIN_N = DW'(RD_LAT);

    logic [1:0]              state_q, state_d;
    logic [ADDR_W-1:0]       start_q;
    logic [CW-1:0]           end_q;
    logic [CW-1:0]           run_end_q;
    logic [CW-1:0]           cnt_q;
    logic [DW-1:0]           drain_q;
    logic [ADDR_W-1:0]       raddr_q;
    logic [31:0]             err_cnt_q;
    logic                    first_vld_q;
    logic [ADDR_W-1:0]       first_addr_q;
    logic [DATA_W-1:0]       first_res_q;
    logic [31:0]             rdata_q;
    // Tag stage k lines up with RAM data once k reaches RD_LAT (address register is stage 0).
    logic [RD_LAT:0]              tag_vld_q;
    logic [RD_LAT:0][ADDR_W-1:0]  tag_addr_q;

    logic              busy;
    logic              wr_ctrl, start_run, abort_run, cmp_fail, push;
    logic [CW-1:0]     end_clamp;
    logic [31:0]       rd_mux;

    assign busy      = (state_q != S_IDLE);
    assign wr_ctrl   = write && (address == 3'd0);
    assign start_run = wr_ctrl && writedata[0] && !busy;
    assign abort_run = wr_ctrl && !writedata[0] && busy;
    assign end_clamp = (end_q > c_MAX_END) ? c_MAX_END : end_q;
    assign push      = (state_q == S_ISSUE) && !abort_run;
    assign cmp_fail  = tag_vld_q[RD_LAT] && (res_data != exp_data) && !abort_run;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_run)
                    state_d = ({1'b0, start_q} < end_clamp) ? S_ISSUE : S_DRAIN;
            end
            S_ISSUE: begin
                if (abort_run)
                    state_d = S_IDLE;
                else if (cnt_q == run_end_q - c_ONE)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_run || drain_q == c_DRAIN_N)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd0: rd_mux = {31'd0, busy};
            3'd1: rd_mux = 32'(start_q);
            3'd2: rd_mux = 32'(end_q);
            3'd3: rd_mux = ID;
            3'd4: rd_mux = err_cnt_q;
            3'd5: rd_mux = {first_vld_q, 31'(first_addr_q)};
            3'd6: rd_mux = 32'(first_res_q);
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge avalon_clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_q      <= '0;
            end_q        <= '0;
            run_end_q    <= '0;
            cnt_q        <= '0;
            drain_q      <= '0;
            raddr_q      <= '0;
            err_cnt_q    <= '0;
            first_vld_q  <= 1'b0;
            first_addr_q <= '0;
            first_res_q  <= '0;
            rdata_q      <= '0;
            tag_vld_q    <= '0;
            tag_addr_q   <= '0;
        end else begin
            state_q <= state_d;

            if (write && !busy) begin
                if (address == 3'd1) start_q <= writedata[ADDR_W-1:0];
                if (address == 3'd2) end_q   <= writedata[CW-1:0];
            end

            if (read)
                rdata_q <= rd_mux;

            if (state_q == S_ISSUE) begin
                raddr_q <= cnt_q[ADDR_W-1:0];
                cnt_q   <= cnt_q + c_ONE;
            end

            drain_q <= (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;

            if (abort_run) begin
                tag_vld_q <= '0;
            end else begin
                tag_vld_q  <= {tag_vld_q[RD_LAT-1:0], push};
                tag_addr_q <= {tag_addr_q[RD_LAT-1:0], cnt_q[ADDR_W-1:0]};
            end

            if (cmp_fail) begin
                err_cnt_q <= err_cnt_q + 32'd1;
                if (!first_vld_q) begin
                    first_vld_q  <= 1'b1;
                    first_addr_q <= tag_addr_q[RD_LAT];
                    first_res_q  <= res_data;
                end
            end

            // A new run starts from clean statistics; pipe is empty in IDLE.
            if (start_run) begin
                cnt_q        <= {1'b0, start_q};
                run_end_q    <= end_clamp;
                err_cnt_q    <= '0;
                first_vld_q  <= 1'b0;
                first_addr_q <= '0;
                first_res_q  <= '0;
            end
        end
    end

    assign readdata   = rdata_q;
    assign r_addr_res = raddr_q;
    assign r_addr_exp = raddr_q;

endmodule

`default_nettype wire

// File: tb/tb_result_check_unit.sv
// ============================================================================
//  Module   : tb_result_check_unit
//  Brief    : Directed bench for result_check_unit with RAM models and a
//             read-back scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_check_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [2:0]        address = 3'd0;
    logic [31:0]       writedata = 32'd0;
    logic [31:0]       readdata;
    logic [ADDR_W-1:0] r_addr_res, r_addr_exp;
    logic [DATA_W-1:0] res_data, exp_data;

    logic [DATA_W-1:0] res_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] res_pipe [RD_LAT];
    logic [DATA_W-1:0] exp_pipe [RD_LAT];

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    result_check_unit #(
        .ID(32'd2), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .avalon_clock(clk),
        .reset(rst),
        .write(write),
        .read(read),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .r_addr_res(r_addr_res),
        .r_addr_exp(r_addr_exp),
        .res_data(res_data),
        .exp_data(exp_data)
    );

    // Synchronous RAM models with RD_LAT cycles from address to q.
    always @(posedge clk) begin
        res_pipe[0] <= res_mem[r_addr_res];
        exp_pipe[0] <= exp_mem[r_addr_exp];
        for (int i = 1; i < RD_LAT; i++) begin
            res_pipe[i] <= res_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
        end
    end
    assign res_data = res_pipe[RD_LAT-1];
    assign exp_data = exp_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] expv);
        @(negedge clk);
        read = 1'b1; address = a;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(negedge clk);
        read = 1'b0;
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic model(input int s, input int e, output int cnt,
                         output logic [31:0] r5, output logic [31:0] r6);
        int ee;
        ee = (e > DEPTH) ? DEPTH : e;
        cnt = 0; r5 = 32'd0; r6 = 32'd0;
        for (int a = s; a < ee; a++) begin
            if (res_mem[a] !== exp_mem[a]) begin
                cnt++;
                if (!r5[31]) begin
                    r5 = 32'h8000_0000 | 32'(a);
                    r6 = res_mem[a];
                end
            end
        end
    endtask

    // Starts a run and polls reg0 every cycle; returns number of busy cycles.
    task automatic run(input int s, input int e, output int busy_cycles);
        wr(3'd1, 32'(s));
        wr(3'd2, 32'(e));
        wr(3'd0, 32'd1);
        read = 1'b1; address = 3'd0;
        busy_cycles = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (readdata[0] === 1'b1) busy_cycles++;
            else break;
        end
        read = 1'b0;
    endtask

    task automatic check_run(input string tag, input int s, input int e);
        int          cyc, cnt, ee, issued;
        logic [31:0] r5, r6;
        ee = (e > DEPTH) ? DEPTH : e;
        issued = (ee > s) ? ee - s : 0;
        model(s, e, cnt, r5, r6);
        run(s, e, cyc);
        check({tag, "_busy"}, 32'(cyc), 32'(issued + RD_LAT + 1));
        rd(3'd4, {tag, "_errcnt"}, 32'(cnt));
        rd(3'd5, {tag, "_first"}, r5);
        rd(3'd6, {tag, "_firstres"}, r6);
    endtask

    initial begin
        int cyc;
        for (int a = 0; a < DEPTH; a++) begin
            res_mem[a] = 32'h1234_0000 + 32'(a);
            exp_mem[a] = 32'h1234_0000 + 32'(a);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_readdata", readdata, 32'd0);
        check("rst_raddr", 32'(r_addr_res), 32'd0);
        for (int r = 0; r < 8; r++)
            rd(3'(r), $sformatf("rst_reg%0d", r), (r == 3) ? 32'd2 : 32'd0);

        check_run("equal", 0, 16);
        check("equal_raddr", 32'(r_addr_res), 32'd15);

        res_mem[5] = 32'h0000_00AA;
        res_mem[9] = 32'h5555_5555;
        check_run("mism", 0, 16);
        rd(3'd6, "mism_res_aa", 32'h0000_00AA);
        rd(3'd7, "reg7_zero", 32'd0);
        repeat (3) @(negedge clk);
        check("readdata_hold", readdata, 32'd0);

        res_mem[10] = 32'hDEAD_BEEF;
        check_run("empty", 10, 10);

        for (int a = DEPTH - 8; a < DEPTH; a++) res_mem[a] = ~exp_mem[a];
        check_run("top", DEPTH - 8, DEPTH);
        rd(3'd5, "top_first_addr", 32'h8000_07F8);
        check("top_raddr", 32'(r_addr_res), 32'd2047);
        check("addr_equal", 32'(r_addr_exp), 32'(r_addr_res));

        check_run("clamp", DEPTH - 3, 4000);
        rd(3'd2, "clamp_end_reg", 32'd4000);

        // Busy-time write protection, then abort on the fourth issue cycle.
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd100);
        wr(3'd0, 32'd1);
        wr(3'd1, 32'd7);
        @(negedge clk);
        wr(3'd0, 32'd0);
        rd(3'd0, "abort_busy", 32'd0);
        rd(3'd1, "busy_wr_reg1", 32'd0);
        rd(3'd4, "abort_errcnt", 32'd0);
        rd(3'd5, "abort_first", 32'd0);

        // Rerun reaches mismatches, then reset lands mid-run.
        wr(3'd0, 32'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_raddr", 32'(r_addr_res), 32'd0);
        for (int r = 0; r < 8; r++)
            rd(3'(r), $sformatf("midrst_reg%0d", r), (r == 3) ? 32'd2 : 32'd0);

        check_run("after_rst", 0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
